// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// Holds the op codes, FSM states and small op-decoding helpers.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // MULT and DIV (even encodings) are the signed flavours.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_operand_cond.sv
// Converts raw rs/rt operands into magnitudes plus the sign bits that the
// fixup step needs to restore a signed result.
module muldiv_operand_cond
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             res_neg,
  output logic             rem_neg
);

  logic ext_a;
  logic ext_b;

  // The extension bit is the sign bit for signed ops and zero otherwise,
  // so one negate path serves both flavours. |0x80000000| stays 0x80000000.
  assign ext_a = op_is_signed(op) & a[WIDTH-1];
  assign ext_b = op_is_signed(op) & b[WIDTH-1];

  assign mag_a   = ext_a ? ((~a) + WIDTH'(1)) : a;
  assign mag_b   = ext_b ? ((~b) + WIDTH'(1)) : b;
  assign res_neg = ext_a ^ ext_b;
  assign rem_neg = ext_a;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply / restoring divide unit owning the HI/LO pair.
// Handshake: start is sampled only in IDLE; busy covers PREP..FIXUP; done pulses one cycle with hi/lo valid.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output state_t           dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state;
  state_t state_nxt;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               res_neg_q;
  logic               rem_neg_q;
  logic               dbz_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               res_neg;
  logic               rem_neg;
  logic               is_div;
  logic               div_zero;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_q;
  logic [WIDTH-1:0]   fix_r;

  muldiv_operand_cond #(.WIDTH(WIDTH)) u_cond (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .res_neg (res_neg),
    .rem_neg (rem_neg)
  );

  assign is_div   = op_is_div(op_q);
  assign div_zero = is_div && (b_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_PREP;
      ST_PREP:  state_nxt = div_zero ? ST_DONE : ST_RUN;
      ST_RUN:   if (cnt == CW'(WIDTH - 1)) state_nxt = ST_FIXUP;
      ST_FIXUP: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // One iteration step. Both algorithms start from acc = {0, |A|} and use b_q
  // (|B| after PREP) as multiplicand or divisor.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
    div_part  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_part - {1'b0, b_q};
    if (is_div) begin
      if (div_trial[WIDTH]) acc_step = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                  acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
    fix_prod = res_neg_q ? -acc : acc;
    fix_q    = res_neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fix_r    = rem_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end
          // MTHI/MTLO still land when issued alongside a launch.
          if (hi_write) hi <= write_data;
          if (lo_write) lo <= write_data;
        end
        ST_PREP: begin
          res_neg_q <= res_neg;
          rem_neg_q <= rem_neg;
          b_q       <= mag_b;
          acc       <= {{WIDTH{1'b0}}, mag_a};
          cnt       <= '0;
          dbz_q     <= div_zero;
          if (div_zero) begin
            hi <= a_q;
            lo <= '1;
          end
        end
        ST_RUN: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        ST_FIXUP: begin
          if (is_div) begin
            hi <= fix_r;
            lo <= fix_q;
          end else begin
            hi <= fix_prod[2*WIDTH-1:WIDTH];
            lo <= fix_prod[WIDTH-1:0];
          end
        end
        ST_DONE: dbz_q <= 1'b0;
        default: dbz_q <= 1'b0;
      endcase
    end
  end

  assign busy        = (state == ST_PREP) || (state == ST_RUN) || (state == ST_FIXUP);
  assign done        = (state == ST_DONE);
  assign div_by_zero = done & dbz_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of ops with expected
// HI/LO/latency, plus hand sequences for ignored writes, MTLO and mid-op reset.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         hi_write = 1'b0;
  logic         lo_write = 1'b0;
  logic [W-1:0] write_data = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  state_t       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    logic         edbz;
    int           elat;
    int           inj;
  } vec_t;

  vec_t vecs[10];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op_i),
    .a           (a_i),
    .b           (b_i),
    .hi_write    (hi_write),
    .lo_write    (lo_write),
    .write_data  (write_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for done, counting cycles from the start edge (cycle 0).
  // inj > 0 pulses start(DIVU)+hi_write during that busy cycle.
  task automatic run_op(input vec_t v);
    logic [W-1:0] old_hi, old_lo;
    logic busy_ok, stable_ok, dbz;
    int lat;
    @(negedge clk);
    old_hi = hi;
    old_lo = lo;
    start = 1'b1;
    op_i = v.op;
    a_i = v.a;
    b_i = v.b;
    @(posedge clk);
    #1 start = 1'b0;
    busy_ok = 1'b1;
    stable_ok = 1'b1;
    dbz = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        dbz = div_by_zero;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hi !== old_hi || lo !== old_lo) stable_ok = 1'b0;
      if (v.inj > 0 && c == v.inj) begin
        start = 1'b1;
        op_i = OP_DIVU;
        hi_write = 1'b1;
        write_data = 32'h0000_AAAA;
      end else begin
        start = 1'b0;
        hi_write = 1'b0;
      end
    end
    start = 1'b0;
    hi_write = 1'b0;
    check({v.name, " latency"}, 64'(lat), 64'(v.elat));
    check({v.name, " hi"}, 64'(hi), 64'(v.ehi));
    check({v.name, " lo"}, 64'(lo), 64'(v.elo));
    check({v.name, " div_by_zero"}, 64'(dbz), 64'(v.edbz));
    check({v.name, " busy window"}, 64'(busy_ok), 64'(1));
    check({v.name, " hi/lo stable while busy"}, 64'(stable_ok), 64'(1));
    @(negedge clk);
    check({v.name, " done is a pulse"}, 64'(done), 64'(0));
    check({v.name, " back to idle"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    vecs[0] = '{"mult -3*7",     OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35, 0};
    vecs[1] = '{"multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35, 0};
    vecs[2] = '{"divu 100/7",    OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 35, 0};
    vecs[3] = '{"div -7/2",      OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, 0};
    vecs[4] = '{"div overflow",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35, 0};
    vecs[5] = '{"divu by zero",  OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2,  0};
    vecs[6] = '{"div 7/-2",      OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 35, 0};
    vecs[7] = '{"mult min*min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 35, 0};
    vecs[8] = '{"div -7 by zero", OP_DIV,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 2,  0};
    vecs[9] = '{"mult 5*6 busy pokes", OP_MULT, 32'd5,    32'd6,         32'h0000_0000, 32'h0000_001E, 1'b0, 35, 10};

    repeat (3) @(negedge clk);
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset div_by_zero", 64'(div_by_zero), 64'(0));
    check("reset state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // MTLO in IDLE lands at the next edge, HI untouched.
    @(negedge clk);
    lo_write = 1'b1;
    write_data = 32'h0000_0055;
    @(posedge clk);
    #1 lo_write = 1'b0;
    check("mtlo lo", 64'(lo), 64'(32'h55));
    check("mtlo hi unchanged", 64'(hi), 64'(0));

    // Reset in the middle of DIV 50/5 clears everything asynchronously.
    @(negedge clk);
    start = 1'b1;
    op_i = OP_DIV;
    a_i = 32'd50;
    b_i = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre-reset busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async reset hi", 64'(hi), 64'(0));
    check("async reset lo", 64'(lo), 64'(0));
    check("async reset busy", 64'(busy), 64'(0));
    check("async reset done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset state", 64'(dbg_state), 64'(ST_IDLE));

    // Fresh MULTU 3*4 launched together with MTHI: write lands, result overwrites.
    start = 1'b1;
    op_i = OP_MULTU;
    a_i = 32'd3;
    b_i = 32'd4;
    hi_write = 1'b1;
    write_data = 32'h0000_0077;
    @(posedge clk);
    #1 start = 1'b0;
    hi_write = 1'b0;
    check("start+mthi hi", 64'(hi), 64'(32'h77));
    check("start+mthi busy", 64'(busy), 64'(1));
    begin
      int lat;
      lat = 0;
      for (int c = 1; c <= 100; c++) begin
        @(negedge clk);
        if (done) begin
          lat = c;
          break;
        end
      end
      check("multu 3*4 latency", 64'(lat), 64'(35));
    end
    check("multu 3*4 hi", 64'(hi), 64'(0));
    check("multu 3*4 lo", 64'(lo), 64'(12));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS pipeline.
- Sits beside the EX stage and is launched by MULT/MULTU/DIV/DIVU.
- Raises Busy so the hazard logic stalls MFHI/MFLO and any later mul/div until the result commits.
- Also services MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand width and number of shift/add (or shift/subtract) iterations.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Start  input  1  launch operation; sampled only in IDLE
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  input  WIDTH  rs operand (multiplicand / dividend)
- B  input  WIDTH  rt operand (multiplier / divisor)
- HiWrite  input  1  MTHI strobe
- LoWrite  input  1  MTLO strobe
- WriteData  input  WIDTH  MTHI/MTLO data
- Busy  output  1  high from the cycle after Start acceptance until the Done cycle, exclusive
- Done  output  1  one-cycle pulse; Hi/Lo hold the new result in this cycle
- DivByZero  output  1  one-cycle pulse coincident with Done when a DIV/DIVU had B==0
- Hi  output  WIDTH  HI register
- Lo  output  WIDTH  LO register

Behaviour:
- Reset (async, Rst_n low):
  - State=IDLE; Hi=Lo=0; Busy=Done=DivByZero=0; iteration counter=0.
  - Asserting reset mid-operation aborts the operation; no partial result is written.
- States: IDLE, PREP, RUN, FIXUP, DONE.
- IDLE:
  - Start=1 latches Op/A/B and moves to PREP.
  - Otherwise HiWrite/LoWrite load WriteData into Hi/Lo at the edge.
  - Start together with HiWrite/LoWrite: the write takes effect and the operation still launches; its result overwrites Hi/Lo later.
- PREP (1 cycle):
  - Signed ops: record result sign and remainder sign; replace each operand with its magnitude (|0x80000000| = 0x80000000 unsigned).
  - Unsigned ops use operands as-is.
  - DIV/DIVU with B==0 goes directly to DONE with Hi=A (original), Lo={WIDTH{1}}, DivByZero=1.
  - Otherwise goes to RUN with counter=0.
- RUN (WIDTH cycles):
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient bits into the low half, remainder into the high half.
  - Counter increments each cycle; at counter==WIDTH-1 goes to FIXUP.
- FIXUP (1 cycle):
  - Signed multiply: negate the 2*WIDTH product if operand signs differ.
  - Signed divide: negate the quotient if signs differ; remainder takes the dividend's sign.
  - Hi/Lo written at the end of FIXUP.
- DONE (1 cycle):
  - Done=1, Busy=0.
  - Returns to IDLE. Start in this cycle is ignored; software must wait one cycle.
- Latency:
  - Normal operation: Start edge at cycle 0; Done high in cycle WIDTH+3 (35 for WIDTH=32).
  - Divide by zero: Done high in cycle 2.
- Busy covers PREP, RUN and FIXUP.
- Start, HiWrite and LoWrite while Busy are ignored.
- Hi/Lo are stable (old values) throughout Busy.
- Signed divide overflow 0x80000000 / -1: Lo=0x80000000, Hi=0, no flag.
- Division truncates toward zero.
- All arithmetic is modulo WIDTH per half; no other exceptions are flagged.

Decomposition:
- Package muldiv_pkg:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encodings.
  - WIDTH default.
- Sub-module muldiv_operand_cond (combinational):
  - Inputs: Op, A, B.
  - Outputs: magnitude operands, result-sign bit, remainder-sign bit.
  - Reuses the sign-extension/zero-extension selection idea for signed vs unsigned handling.
- The FSM, counter, iteration datapath and Hi/Lo registers live in muldiv_sequencer.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> Done at cycle 35, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high cycles 1-34.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. DIVU A=100, B=7 -> Lo=0x0000000E, Hi=0x00000002.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=0x1234, B=0 -> Done and DivByZero pulse in cycle 2, Hi=0x1234, Lo=0xFFFFFFFF, Busy high only cycle 1.
- Launch MULT 5*6, then during RUN pulse Start (Op=DIVU) and HiWrite with WriteData=0xAAAA -> both ignored; final Hi=0, Lo=30. Then in IDLE, LoWrite 0x55 -> Lo=0x55 next cycle.
- Launch DIV 50/5, drop Rst_n at cycle 10 for 2 cycles -> Hi=Lo=0 and Busy=Done=0 immediately (async). After release, IDLE; a fresh MULTU 3*4 completes with Lo=12, Hi=0.
